fifo_ptr_ctrl: RTL and testbench

FIFO_PTR_CTRL -- requirements
Module: fifo_ptr_ctrl

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_ptr_counter.sv | 48 ++++
 rtl/fifo_ptr_ctrl.sv | 84 ++++++++
 tb/tb_fifo_ptr_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg -- shared definitions for the FIFO pointer controller.
//   OSTD_NUM_DEF : default FIFO depth in entries
//   ptr_width()  : pointer width (address bits + wrap bit)
//   bin2gray()   : binary to reflected Gray code, 32-bit container
package fifo_pkg;

    localparam int OSTD_NUM_DEF = 8;

    function automatic int ptr_width(input int addr_bits);
        return addr_bits + 1;
    endfunction

    // Callers size-cast the result down to their pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/fifo_ptr_counter.sv
// fifo_ptr_counter -- one FIFO pointer with wrap bit.
//   clk_in, reset_in : clock, synchronous active-high reset
//   inc              : advance pointer this cycle
//   ptr              : registered pointer, MSB is the wrap bit
//   gray             : registered Gray code of ptr (only with FIFO_PTR_GRAY_EN)
module fifo_ptr_counter
    import fifo_pkg::*;
#(
    parameter int PTR_SIZE = 3
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              inc,
    output logic [PTR_SIZE:0] ptr
`ifdef FIFO_PTR_GRAY_EN
    ,
    output logic [PTR_SIZE:0] gray
`endif
);

    localparam int PW = ptr_width(PTR_SIZE);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_nxt;

    // Natural binary overflow gives the address roll-over and wrap-bit toggle.
    assign w_ptr_nxt = inc ? r_ptr + 1'b1 : r_ptr;

    always_ff @(posedge clk_in) begin
        if (reset_in) r_ptr <= '0;
        else          r_ptr <= w_ptr_nxt;
    end

    assign ptr = r_ptr;

`ifdef FIFO_PTR_GRAY_EN
    logic [PW-1:0] r_gray;

    // Encoded from the next value so gray tracks ptr in the same cycle.
    always_ff @(posedge clk_in) begin
        if (reset_in) r_gray <= '0;
        else          r_gray <= PW'(bin2gray(32'(w_ptr_nxt)));
    end

    assign gray = r_gray;
`endif

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl -- read/write pointer control for a power-of-two FIFO.
//   clk_in, reset_in        : clock, synchronous active-high reset
//   trans_write/trans_read  : producer / consumer requests
//   fifo_wenable/renable    : request accepted this cycle (memory strobes)
//   write_ptr/read_ptr      : pointers, MSB is the wrap bit
//   wr_addr/rd_addr         : address part of the pointers
//   fill_count              : stored entries, 0..OSTD_NUM
//   write_ptr_gray/read_ptr_gray : Gray pointers, present only when
//                             FIFO_PTR_GRAY_EN is defined
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int OSTD_NUM = OSTD_NUM_DEF,
    parameter int PTR_SIZE = $clog2(OSTD_NUM)
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic                trans_write,
    input  logic                trans_read,
    output logic                fifo_wenable,
    output logic                fifo_renable,
    output logic [PTR_SIZE:0]   write_ptr,
    output logic [PTR_SIZE:0]   read_ptr,
    output logic [PTR_SIZE-1:0] wr_addr,
    output logic [PTR_SIZE-1:0] rd_addr,
    output logic [PTR_SIZE:0]   fill_count
`ifdef FIFO_PTR_GRAY_EN
    ,
    output logic [PTR_SIZE:0]   write_ptr_gray,
    output logic [PTR_SIZE:0]   read_ptr_gray
`endif
);

    logic w_full;
    logic w_empty;
    logic [PTR_SIZE:0] r_fill;

    assign w_full  = (write_ptr[PTR_SIZE] != read_ptr[PTR_SIZE]) &&
                     (write_ptr[PTR_SIZE-1:0] == read_ptr[PTR_SIZE-1:0]);
    assign w_empty = (write_ptr == read_ptr);

    // Reset masks the strobes so no memory access happens in a reset cycle.
    assign fifo_wenable = trans_write & ~w_full  & ~reset_in;
    assign fifo_renable = trans_read  & ~w_empty & ~reset_in;

    fifo_ptr_counter #(.PTR_SIZE(PTR_SIZE)) u_wr_cnt (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .inc      (fifo_wenable),
        .ptr      (write_ptr)
`ifdef FIFO_PTR_GRAY_EN
        ,
        .gray     (write_ptr_gray)
`endif
    );

    fifo_ptr_counter #(.PTR_SIZE(PTR_SIZE)) u_rd_cnt (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .inc      (fifo_renable),
        .ptr      (read_ptr)
`ifdef FIFO_PTR_GRAY_EN
        ,
        .gray     (read_ptr_gray)
`endif
    );

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_fill <= '0;
        end else begin
            case ({fifo_wenable, fifo_renable})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign fill_count = r_fill;
    assign wr_addr    = write_ptr[PTR_SIZE-1:0];
    assign rd_addr    = read_ptr[PTR_SIZE-1:0];

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb_fifo_ptr_ctrl -- directed plus random check of fifo_ptr_ctrl against
// an occupancy-count reference model. Gray checks with FIFO_PTR_GRAY_EN.
module tb_fifo_ptr_ctrl;

    localparam int DEPTH = 8;
    localparam int P     = 3;
    localparam int MOD   = 2 * DEPTH;

    logic         clk_in = 1'b0;
    logic         reset_in = 1'b1;
    logic         trans_write = 1'b0;
    logic         trans_read = 1'b0;
    logic         fifo_wenable, fifo_renable;
    logic [P:0]   write_ptr, read_ptr, fill_count;
    logic [P-1:0] wr_addr, rd_addr;
`ifdef FIFO_PTR_GRAY_EN
    logic [P:0]   write_ptr_gray, read_ptr_gray;
`endif

    fifo_ptr_ctrl #(.OSTD_NUM(DEPTH), .PTR_SIZE(P)) dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .trans_write  (trans_write),
        .trans_read   (trans_read),
        .fifo_wenable (fifo_wenable),
        .fifo_renable (fifo_renable),
        .write_ptr    (write_ptr),
        .read_ptr     (read_ptr),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .fill_count   (fill_count)
`ifdef FIFO_PTR_GRAY_EN
        ,
        .write_ptr_gray (write_ptr_gray),
        .read_ptr_gray  (read_ptr_gray)
`endif
    );

    always #5 clk_in = ~clk_in;

    int vectors = 0;
    int fails   = 0;

    // Reference model: entry count plus free-running pointer positions.
    int cnt = 0;
    int wp  = 0;
    int rp  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Gray of an integer pointer, computed bit-by-bit from the definition.
    function automatic int gray_of(input int v);
        int g = 0;
        for (int b = 0; b <= P; b++) begin
            int hi = (b == P) ? 0 : ((v >> (b + 1)) & 1);
            g |= ((((v >> b) & 1) ^ hi) << b);
        end
        return g;
    endfunction

    // One clock: drive at negedge, check strobes, then check state after the edge.
    task automatic cycle(input bit w, input bit r, input bit rst);
        bit exp_we, exp_re;
        int pwg, prg;
        @(negedge clk_in);
        trans_write = w;
        trans_read  = r;
        reset_in    = rst;
        #1;
        exp_we = w && !rst && (cnt < DEPTH);
        exp_re = r && !rst && (cnt > 0);
        chk("wenable", 32'(fifo_wenable), 32'(exp_we));
        chk("renable", 32'(fifo_renable), 32'(exp_re));
        pwg = gray_of(wp);
        prg = gray_of(rp);
        @(posedge clk_in);
        if (rst) begin
            cnt = 0; wp = 0; rp = 0;
        end else begin
            if (exp_we) begin wp = (wp + 1) % MOD; cnt++; end
            if (exp_re) begin rp = (rp + 1) % MOD; cnt--; end
        end
        #1;
        chk("write_ptr",  32'(write_ptr),  32'(wp));
        chk("read_ptr",   32'(read_ptr),   32'(rp));
        chk("fill_count", 32'(fill_count), 32'(cnt));
        chk("wr_addr",    32'(wr_addr),    32'(wp % DEPTH));
        chk("rd_addr",    32'(rd_addr),    32'(rp % DEPTH));
`ifdef FIFO_PTR_GRAY_EN
        chk("wgray", 32'(write_ptr_gray), 32'(gray_of(wp)));
        chk("rgray", 32'(read_ptr_gray),  32'(gray_of(rp)));
        if (exp_we && !rst) chk("wgray_step", 32'($countones(pwg ^ gray_of(wp))), 32'd1);
        if (exp_re && !rst) chk("rgray_step", 32'($countones(prg ^ gray_of(rp))), 32'd1);
`else
        if (pwg != prg) begin end
`endif
    endtask

    initial begin
        // Reset state
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        chk("rst_wptr", 32'(write_ptr), 32'd0);

        // Fill to full, then a rejected 9th write
        for (int i = 0; i < 8; i++) cycle(1, 0, 0);
        chk("full_wptr", 32'(write_ptr), 32'b1000);
        chk("full_fill", 32'(fill_count), 32'd8);
        cycle(1, 0, 0);

        // Drain to empty, then a rejected 9th read
        for (int i = 0; i < 8; i++) cycle(0, 1, 0);
        chk("empty_rptr", 32'(read_ptr), 32'b1000);
        chk("empty_fill", 32'(fill_count), 32'd0);
        cycle(0, 1, 0);
        // Both while empty: write only
        cycle(1, 1, 0);

        // Refill to full, both at once: read only
        for (int i = 0; i < 7; i++) cycle(1, 0, 0);
        chk("refull_fill", 32'(fill_count), 32'd8);
        cycle(1, 1, 0);
        chk("full_both_fill", 32'(fill_count), 32'd7);
        cycle(1, 0, 0);
        chk("retry_write_fill", 32'(fill_count), 32'd8);

        // Down to 3, then 20 cycles of simultaneous traffic
        for (int i = 0; i < 5; i++) cycle(0, 1, 0);
        chk("three_fill", 32'(fill_count), 32'd3);
        for (int i = 0; i < 20; i++) cycle(1, 1, 0);
        chk("stream_fill", 32'(fill_count), 32'd3);

        // Up to 5, then reset with requests high
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        chk("five_fill", 32'(fill_count), 32'd5);
        cycle(1, 1, 1);
        chk("midrst_fill", 32'(fill_count), 32'd0);
        cycle(1, 1, 0);

        // Interleaved writes and reads exercising Gray steps
        for (int i = 0; i < 16; i++) begin
            cycle(1, 0, 0);
            cycle(1, 1, 0);
        end

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 49) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
